// File: rtl/seq_detector_fsm.sv
// Parametrised Mealy serial pattern detector with KMP fallback transitions built at elaboration.
// Define SEQ_DET_MATCH_COUNT_EN to enable the saturating o_match_count counter.
module seq_detector_fsm #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     COUNT_W     = 8,
  localparam int                    STATE_W     = ($clog2(PATTERN_LEN) > 1) ? $clog2(PATTERN_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_input,
  input  logic               i_clear,
  output logic               o_output,
  output logic               o_match_q,
  output logic [STATE_W-1:0] o_current_state,
  output logic [STATE_W-1:0] o_next_state,
  output logic [COUNT_W-1:0] o_match_count
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(PATTERN_LEN - 1);

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic bit pat_bit(input int i);
    return PATTERN[PATTERN_LEN-1-i];
  endfunction

  // Longest pattern prefix (shorter than the whole pattern) that is a suffix of
  // the s matched bits followed by b. A completed match therefore lands on the
  // longest proper border, unless overlap is disabled.
  function automatic int kmp_next(input int s, input int b);
    int best;
    bit ok;
    int idx;
    bit sb;
    best = 0;
    for (int k = 1; k < PATTERN_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          idx = s + 1 - k + j;
          sb  = (idx < s) ? pat_bit(idx) : b[0];
          if (pat_bit(j) != sb) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    if (!OVERLAP && (s == PATTERN_LEN - 1) && (b[0] == pat_bit(s))) best = 0;
    return best;
  endfunction

  logic [STATE_W-1:0] nxt_on0 [PATTERN_LEN];
  logic [STATE_W-1:0] nxt_on1 [PATTERN_LEN];
  logic               exp_bit [PATTERN_LEN];

  for (genvar g = 0; g < PATTERN_LEN; g++) begin : g_tbl
    localparam logic [STATE_W-1:0] N0 = STATE_W'(kmp_next(g, 0));
    localparam logic [STATE_W-1:0] N1 = STATE_W'(kmp_next(g, 1));
    localparam bit                 EB = pat_bit(g);
    assign nxt_on0[g] = N0;
    assign nxt_on1[g] = N1;
    assign exp_bit[g] = EB;
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               bit_ok;

  assign bit_ok = (i_input == exp_bit[state]);

  always_ff @(posedge clk) begin
    if (rst) state <= '0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (i_clear)      next_state = '0;
    else if (i_valid) next_state = i_input ? nxt_on1[state] : nxt_on0[state];
  end

  always_comb begin
    o_output = 1'b0;
    if (!i_clear && i_valid && (state == LAST_STATE) && bit_ok) o_output = 1'b1;
  end

  // ---- registered match stage ----
  always_ff @(posedge clk) begin
    if (rst) o_match_q <= 1'b0;
    else     o_match_q <= o_output;
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [COUNT_W-1:0] match_cnt;

  always_ff @(posedge clk) begin
    if (rst)           match_cnt <= '0;
    else if (o_output) match_cnt <= sat_inc(match_cnt);
  end

  assign o_match_count = match_cnt;
`else
  assign o_match_count = '0;
`endif

  assign o_current_state = state;
  assign o_next_state    = next_state;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Bench for seq_detector_fsm: 1011 detector, overlapping and non-overlapping instances
// checked against a history-based reference model, directed tables and random traffic.
module tb_seq_detector_fsm;

  localparam int         PL  = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst, v, d, c;
  logic       o1, mq1, o0, mq0;
  logic [1:0] s1, n1, s0, n0;
  logic [1:0] cnt1;
  logic [7:0] cnt0;

  always #5 clk = ~clk;

  seq_detector_fsm #(.PATTERN_LEN(PL), .PATTERN(PAT), .OVERLAP(1'b1), .COUNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .i_valid(v), .i_input(d), .i_clear(c),
    .o_output(o1), .o_match_q(mq1), .o_current_state(s1), .o_next_state(n1),
    .o_match_count(cnt1)
  );

  seq_detector_fsm #(.PATTERN_LEN(PL), .PATTERN(PAT), .OVERLAP(1'b0), .COUNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .i_valid(v), .i_input(d), .i_clear(c),
    .o_output(o0), .o_match_q(mq0), .o_current_state(s0), .o_next_state(n0),
    .o_match_count(cnt0)
  );

  int checks   = 0;
  int failures = 0;

  bit pat_b [PL];
  bit h0[$];
  bit h1[$];
  int es0, eo0, en0, es1, eo1, en1;
  int mq0_m = 0, mq1_m = 0, cnt0_m = 0, cnt1_m = 0;
  bit cur_r, cur_v, cur_d, cur_c;

  typedef struct {
    bit r, vv, dd, cc;
    int s1, o1, n1, s0, o0;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Longest prefix of the pattern, shorter than the pattern, ending the history.
  function automatic int state_of(input bit q[$]);
    bit ok;
    for (int k = PL - 1; k > 0; k--) begin
      if (q.size() >= k) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (q[q.size() - k + j] != pat_b[j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic int ends_pat(input bit q[$]);
    if (q.size() < PL) return 0;
    for (int j = 0; j < PL; j++)
      if (q[q.size() - PL + j] != pat_b[j]) return 0;
    return 1;
  endfunction

  function automatic void model_eval(input bit q[$], input bit ovl, input bit vv, input bit bb,
                                     input bit cc, output int es, output int eo, output int en);
    bit t[$];
    es = state_of(q);
    eo = 0;
    en = es;
    if (cc) en = 0;
    else if (vv) begin
      t = q;
      t.push_back(bb);
      eo = ends_pat(t);
      en = (eo != 0 && !ovl) ? 0 : state_of(t);
    end
  endfunction

  function automatic void model_hist(input bit q[$], input bit ovl, input bit rr, input bit vv,
                                     input bit bb, input bit cc, input int eo, output bit qo[$]);
    qo = q;
    if (rr || cc) qo.delete();
    else if (vv) begin
      qo.push_back(bb);
      if (eo != 0 && !ovl) qo.delete();
      while (qo.size() > PL) void'(qo.pop_front());
    end
  endfunction

  task automatic drive(input bit rr, input bit vv, input bit bb, input bit cc);
    rst = rr; v = vv; d = bb; c = cc;
    cur_r = rr; cur_v = vv; cur_d = bb; cur_c = cc;
    @(negedge clk);
    model_eval(h1, 1'b1, vv, bb, cc, es1, eo1, en1);
    model_eval(h0, 1'b0, vv, bb, cc, es0, eo0, en0);
    check("state1", s1, es1);
    check("out1", o1, eo1);
    check("next1", n1, en1);
    check("match_q1", mq1, mq1_m);
    check("count1", cnt1, cnt1_m);
    check("state0", s0, es0);
    check("out0", o0, eo0);
    check("next0", n0, en0);
    check("match_q0", mq0, mq0_m);
    check("count0", cnt0, cnt0_m);
  endtask

  task automatic advance();
    bit q[$];
    @(posedge clk);
    if (cur_r) begin
      mq1_m = 0; mq0_m = 0; cnt1_m = 0; cnt0_m = 0;
    end else begin
      mq1_m = eo1;
      mq0_m = eo0;
`ifdef SEQ_DET_MATCH_COUNT_EN
      if (eo1 != 0 && cnt1_m < 3)   cnt1_m++;
      if (eo0 != 0 && cnt0_m < 255) cnt0_m++;
`endif
    end
    model_hist(h1, 1'b1, cur_r, cur_v, cur_d, cur_c, eo1, q);
    h1 = q;
    model_hist(h0, 1'b0, cur_r, cur_v, cur_d, cur_c, eo0, q);
    h0 = q;
    #1;
  endtask

  task automatic cycle(input bit rr, input bit vv, input bit bb, input bit cc);
    drive(rr, vv, bb, cc);
    advance();
  endtask

  bit fb_bits [6] = '{1, 0, 1, 0, 1, 1};
  int fb_st   [6] = '{0, 1, 2, 3, 2, 3};
  int fb_out  [6] = '{0, 0, 0, 0, 0, 1};
  bit cs_bits [16] = '{1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};

  initial begin
    int nmatch;
    for (int i = 0; i < PL; i++) pat_b[i] = PAT[PL-1-i];

    tbl[0] = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 0, 2, 1, 0};
    tbl[3] = '{0, 1, 1, 0, 2, 0, 3, 2, 0};
    tbl[4] = '{0, 1, 1, 0, 3, 1, 1, 3, 1};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 2, 0, 0};
    tbl[6] = '{0, 1, 1, 0, 2, 0, 3, 0, 0};
    tbl[7] = '{0, 1, 1, 0, 3, 1, 1, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 1, 0, 1, 1, 0};

    rst = 1'b1; v = 1'b1; d = 1'b1; c = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, first match and overlap stream 1011011
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].vv, tbl[i].dd, tbl[i].cc);
      check("tbl_state1", s1, tbl[i].s1);
      check("tbl_out1", o1, tbl[i].o1);
      check("tbl_next1", n1, tbl[i].n1);
      check("tbl_state0", s0, tbl[i].s0);
      check("tbl_out0", o0, tbl[i].o0);
      advance();
    end

    // KMP fallback from state 3 to state 2
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, fb_bits[i], 0);
      check("fallback_state", s1, fb_st[i]);
      check("fallback_out", o1, fb_out[i]);
      advance();
    end
    drive(0, 0, 0, 0);
    check("match_q_pulse", mq1, 1);
    advance();
    drive(0, 0, 0, 0);
    check("match_q_width", mq1, 0);
    advance();

    // Valid gaps hold the state
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    drive(0, 0, 0, 0); check("gap_hold1", s1, 1); advance();
    cycle(0, 1, 0, 0);
    drive(0, 0, 1, 0); check("gap_hold2", s1, 2); advance();
    cycle(0, 1, 1, 0);
    drive(0, 1, 1, 0); check("gap_match", o1, 1); advance();

    // Clear overrides a would-be match
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    drive(0, 1, 1, 1); check("clear_no_match", o1, 0); advance();
    drive(0, 1, 1, 0); check("clear_state", s1, 0); check("clear_out", o1, 0); advance();
    drive(0, 0, 0, 0); check("clear_then", s1, 1); advance();

    // Reset mid-pattern
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    drive(1, 1, 1, 0); check("rst_mid_state", s1, 2); advance();
    drive(0, 1, 1, 0); check("rst_mid_after", s1, 0); check("rst_mid_out", o1, 0); advance();

    // Counter saturation on the 2-bit counter
    cycle(1, 0, 0, 0);
    nmatch = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, cs_bits[i], 0);
      if (i >= 3 && (i % 3) == 0) begin
        nmatch++;
`ifdef SEQ_DET_MATCH_COUNT_EN
        check("count_sat", cnt1, (nmatch > 3) ? 3 : nmatch);
`else
        check("count_off", cnt1, 0);
`endif
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
